pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction fetch and next-PC sequencer for the single-cycle MIPS datapath. Holds a loadable instruction memory, presents the current instruction and PC to the opcode decoder, and consumes the decoder's `Branch`/`jump` outputs plus the ALU `zero` flag to pick the next PC. It is the upstream end of the control interface: it produces the opcode that the control block decodes and acts on the flow-control signals that block returns.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words. Must be a power of two.
- `RESET_PC`, 32'h0000_0000: first fetch address after `start`. Word aligned.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `load_en` input 1: write `load_data` to `imem[load_addr]`. Honoured only in IDLE or HALT.
- `load_addr` input log2(IMEM_DEPTH): word index for the load.
- `load_data` input 32: instruction word for the load.
- `start` input 1: begin execution. Honoured only in IDLE or HALT.
- `stall` input 1: freeze fetch for this cycle. Honoured only in RUN.
- `branch` input 1: decoder `Branch` output for the current `instr_out`.
- `branch_ne` input 1: qualifies `branch` as BNE. 0 means BEQ.
- `jump` input 1: decoder `jump` output for the current `instr_out`.
- `zero` input 1: ALU zero flag for the current instruction.
- `instr_out` output 32: current instruction, registered.
- `opcode` output 6: `instr_out[31:26]`, combinational.
- `pc_out` output 32: address of `instr_out`, registered.
- `pc_plus4` output 32: `pc_out + 4`, combinational.
- `valid` output 1: `instr_out` is live. Equals (state == RUN).
- `halted` output 1: state == HALT.
- `fault` output 1: sticky flag. Set when the fetch address falls outside imem.
- `instr_count` output 16: number of instructions fetched since `start`. Saturates at 16'hFFFF.

## Operation
- States:
  - IDLE (reset state): program load allowed.
  - RUN: fetching.
  - HALT: fetching stopped. Load and restart allowed.
- IDLE/HALT with `start`=1:
  - `pc_out`<=RESET_PC; `instr_out`<=imem[RESET_PC[..:2]].
  - `instr_count`<=1; `fault`<=0; go to RUN.
  - If `load_en` and `start` are both high in the same cycle, the load is performed first. A load to the RESET_PC word is visible in that same fetch (write-first).
- RUN next-PC rule, evaluated on the current `instr_out`, in priority order:
  1. `jump` -> `{pc_plus4[31:28], instr_out[25:0], 2'b00}`.
  2. `branch & (zero ^ branch_ne)` -> `pc_plus4 + {{14{instr_out[15]}}, instr_out[15:0], 2'b00}`, modulo 2^32.
  3. Otherwise -> `pc_plus4`.
- RUN advancing edge (`stall`=0, not a halt or fault case):
  - `pc_out`<=next_pc; `instr_out`<=imem[next_pc[..:2]].
  - `instr_count` += 1, saturating.
- Halt instruction: `instr_out` == 32'hFFFF_FFFF in RUN with `stall`=0.
  - Next edge -> HALT.
  - `pc_out` and `instr_out` hold their values; no count increment.
- Out-of-range fetch: next_pc[31:2] >= IMEM_DEPTH on an advancing edge.
  - -> HALT with `fault`<=1.
  - `pc_out`<=next_pc and `instr_out`<=0; no count increment.
- `stall`=1 in RUN: all registers hold, including the count. The halt check is deferred until the stall clears.
- `load_en` in RUN is ignored. `start` in RUN is ignored.
- The low two bits of next_pc are always 0 by construction. No misalignment handling is needed.

## Timing
- Reset values:
  - state=IDLE.
  - `pc_out`=RESET_PC; `instr_out`=0.
  - `valid`=0; `halted`=0; `fault`=0; `instr_count`=0.
  - imem contents are not cleared.
- `rst` has priority over every other input. Reset mid-RUN returns to IDLE on that edge.
- Latency:
  - `start` edge -> first instruction valid in the same cycle as `valid`=1.
  - Each taken branch or jump is applied on the next edge. There are no delay slots and no bubbles.
- Memory writes take effect on the edge. Reads are synchronous to the fetch edge.
- `opcode` and `pc_plus4` follow the registers combinationally. Decoder feedback (`branch`, `jump`, `zero`) must settle within the same cycle.

## Test plan
- Load ADDI, ADDI, 32'hFFFFFFFF at words 0-2; pulse `start` -> `pc_out` 0, 4, 8 with `valid`=1; then HALT with `pc_out`=8, `halted`=1, `instr_count`=3.
- BEQ at pc 4 with imm=16'hFFFF and `branch`=1, `zero`=1 -> next `pc_out`=4. Repeat with `zero`=0 -> next `pc_out`=8. Repeat with `branch_ne`=1, `zero`=0 -> next `pc_out`=4.
- J with target 26'h000010 at pc 0, with `jump` and `branch` both asserted -> next `pc_out`=32'h40 (jump wins).
- `stall` held 3 cycles mid-RUN -> `pc_out`, `instr_out` and `instr_count` unchanged; on release, advances by 4. A `load_en` pulse during RUN leaves imem unchanged (verify via reload-free restart).
- Jump to word 64 (IMEM_DEPTH=64) -> HALT, `fault`=1, `pc_out`=32'h100, `instr_out`=0; a subsequent `start` clears `fault` and fetches from RESET_PC.
- `rst` asserted during RUN at pc 12 -> next cycle all outputs at reset values; `start` without reloading refetches the original program from pc 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch and next-PC sequencer for a single-cycle MIPS datapath.
// Holds a loadable instruction memory and presents the current instruction and
// its PC to the opcode decoder. The decoder's Branch/jump outputs and the ALU
// zero flag are consumed in the same cycle to select the next PC.
//
// Parameters
//   IMEM_DEPTH  instruction memory depth in 32-bit words (power of two, >= 2)
//   RESET_PC    first fetch address after start (word aligned)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   load_en/addr/data        program load, honoured in IDLE or HALT only
//   start                    begin execution, honoured in IDLE or HALT only
//   stall                    freeze fetch for this cycle, honoured in RUN only
//   branch, branch_ne, jump  decoder feedback for the current instruction
//   zero                     ALU zero flag for the current instruction
//   instr_out, pc_out        current instruction and its address (registered)
//   opcode, pc_plus4         combinational views of instr_out / pc_out
//   valid, halted            state == RUN / state == HALT
//   fault                    sticky out-of-range fetch flag
//   instr_count              instructions fetched since start, saturating
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          branch_ne,
    input  logic                          jump,
    input  logic                          zero,
    output logic [31:0]                   instr_out,
    output logic [5:0]                    opcode,
    output logic [31:0]                   pc_out,
    output logic [31:0]                   pc_plus4,
    output logic                          valid,
    output logic                          halted,
    output logic                          fault,
    output logic [15:0]                   instr_count
);

    localparam int            AW        = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] START_IDX = RESET_PC[AW+1:2];
    localparam logic [31:0]   HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        fault_q;
    logic [15:0] count_q;

    logic [31:0] imem_q [IMEM_DEPTH];

    logic [31:0] pc_plus4_d;
    logic [31:0] br_off_d;
    logic [31:0] pc_d;
    logic [31:0] start_word_d;
    logic        take_branch_d;
    logic        out_of_range_d;
    logic        load_ok_d;

    assign pc_plus4_d = pc_q + 32'd4;

    // Word offset sign-extended and shifted to a byte offset.
    assign br_off_d      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign take_branch_d = branch & (zero ^ branch_ne);

    always_comb begin
        pc_d = pc_plus4_d;
        if (jump) begin
            pc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
        end else if (take_branch_d) begin
            pc_d = pc_plus4_d + br_off_d;
        end
    end

    assign out_of_range_d = (pc_d[31:2] >= 30'(IMEM_DEPTH));

    // Loads are only accepted while not fetching; reset blocks them too.
    assign load_ok_d = !rst && load_en && (state_q != RUN);

    // A load landing on the start word in the start cycle is seen by that fetch.
    assign start_word_d = (load_en && (load_addr == START_IDX)) ? load_data
                                                                : imem_q[START_IDX];

    // Instruction memory: contents survive reset.
    always_ff @(posedge clk) begin
        if (load_ok_d) begin
            imem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            fault_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_q <= RUN;
                        pc_q    <= RESET_PC;
                        instr_q <= start_word_d;
                        fault_q <= 1'b0;
                        count_q <= 16'd1;
                    end
                end
                RUN: begin
                    // A stall holds everything, including the pending halt check.
                    if (!stall) begin
                        if (instr_q == HALT_WORD) begin
                            state_q <= HALT;
                        end else if (out_of_range_d) begin
                            state_q <= HALT;
                            fault_q <= 1'b1;
                            pc_q    <= pc_d;
                            instr_q <= 32'd0;
                        end else begin
                            pc_q    <= pc_d;
                            instr_q <= imem_q[pc_d[AW+1:2]];
                            if (count_q != 16'hFFFF) begin
                                count_q <= count_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_out   = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign valid       = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. A behavioural model of the fetch
// unit (program memory array, architectural PC/instruction/count/fault and a
// three-valued run state) is advanced on every rising edge from the same
// inputs the DUT sees; a compare process checks every DUT output against it
// on each falling edge. Directed scenarios add literal expectations that pin
// the model, followed by a counter-saturation run and a randomized phase.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int DEPTH = 64;

    localparam logic [31:0] ADDI_A = 32'h2008_0001;
    localparam logic [31:0] ADDI_B = 32'h2009_0002;
    localparam logic [31:0] ADDI_C = 32'h2010_0003;
    localparam logic [31:0] ADDI_D = 32'h2011_0004;
    localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        zero;
    logic [31:0] instr_out;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    pc_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .stall       (stall),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .zero        (zero),
        .instr_out   (instr_out),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .valid       (valid),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 = idle, 1 = running, 2 = halted
    logic [31:0] m_mem [DEPTH];
    int          m_state = 0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic        m_fault = 1'b0;
    int          m_cnt   = 0;

    always @(posedge clk) begin
        logic [31:0] p4;
        logic [31:0] tgt;
        int          off;
        if (rst) begin
            m_state = 0;
            m_pc    = 32'd0;
            m_instr = 32'd0;
            m_fault = 1'b0;
            m_cnt   = 0;
        end else if (m_state != 1) begin
            if (load_en) m_mem[load_addr] = load_data;
            if (start) begin
                m_state = 1;
                m_pc    = 32'd0;
                m_instr = m_mem[0];
                m_cnt   = 1;
                m_fault = 1'b0;
            end
        end else if (!stall) begin
            if (m_instr == HALTW) begin
                m_state = 2;
            end else begin
                p4 = m_pc + 32'd4;
                if (jump) begin
                    tgt = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
                end else if (branch && (zero != branch_ne)) begin
                    off = int'($signed(m_instr[15:0])) * 4;
                    tgt = p4 + 32'(off);
                end else begin
                    tgt = p4;
                end
                if ((tgt >> 2) >= DEPTH) begin
                    m_state = 2;
                    m_fault = 1'b1;
                    m_pc    = tgt;
                    m_instr = 32'd0;
                end else begin
                    m_pc    = tgt;
                    m_instr = m_mem[tgt >> 2];
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc_out",      pc_out,              m_pc);
            chk("m_instr_out",   instr_out,           m_instr);
            chk("m_opcode",      32'(opcode),         32'(m_instr >> 26));
            chk("m_pc_plus4",    pc_plus4,            m_pc + 32'd4);
            chk("m_valid",       32'(valid),          32'(m_state == 1));
            chk("m_halted",      32'(halted),         32'(m_state == 2));
            chk("m_fault",       32'(fault),          32'(m_fault));
            chk("m_instr_count", 32'(instr_count),    32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clr_in();
        load_en = 0; load_addr = '0; load_data = '0; start = 0; stall = 0;
        branch = 0; branch_ne = 0; jump = 0; zero = 0;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en = 1; load_addr = 6'(a); load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    pc_out,             32'h0);
        chk({tag, "_instr"}, instr_out,          32'h0);
        chk({tag, "_valid"}, 32'(valid),         32'h0);
        chk({tag, "_halt"},  32'(halted),        32'h0);
        chk({tag, "_fault"}, 32'(fault),         32'h0);
        chk({tag, "_count"}, 32'(instr_count),   32'h0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [15:0] imm;
        case ($urandom_range(0, 4))
            0: w = HALTW;
            1: w = {6'h02, 20'd0, 6'($urandom_range(0, 63))};
            2: begin
                imm = 16'($urandom_range(0, 16)) - 16'd8;
                w   = {6'h04, 10'd0, imm};
            end
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        clr_in();
        rst = 1;
        tick();
        cmp_en = 1;
        tick();
        rst = 0;
        chk_reset("reset");

        // Program 1: ADDI, ADDI, halt; remaining words cleared.
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, (i == 0) ? ADDI_A : (i == 1) ? ADDI_B : (i == 2) ? HALTW : 32'd0);
        end
        do_start();
        chk("p1_pc0",     pc_out,             32'h0);
        chk("p1_instr0",  instr_out,          ADDI_A);
        chk("p1_opcode0", 32'(opcode),        32'h08);
        chk("p1_valid0",  32'(valid),         32'h1);
        tick();
        chk("p1_pc4",     pc_out,             32'h4);
        tick();
        chk("p1_pc8",     pc_out,             32'h8);
        chk("p1_cnt3",    32'(instr_count),   32'd3);
        tick();
        chk("p1_halted",  32'(halted),        32'h1);
        chk("p1_hpc",     pc_out,             32'h8);
        chk("p1_hcnt",    32'(instr_count),   32'd3);
        chk("p1_hvalid",  32'(valid),         32'h0);

        // BEQ / BNE at pc 4 with imm = -1 word.
        load_word(1, 32'h1000_FFFF);
        do_start();
        tick();
        chk("beq_at4", pc_out, 32'h4);
        branch = 1; zero = 1;
        tick();
        chk("beq_taken", pc_out, 32'h4);
        zero = 0;
        tick();
        chk("beq_not_taken", pc_out, 32'h8);
        branch = 0;
        tick();
        do_start();
        tick();
        branch = 1; branch_ne = 1; zero = 0;
        tick();
        chk("bne_taken", pc_out, 32'h4);
        branch = 0; branch_ne = 0;
        tick();
        tick();
        chk("bne_halted", 32'(halted), 32'h1);

        // Jump has priority over a taken branch.
        load_word(0, 32'h0800_0010);
        load_word(16, HALTW);
        do_start();
        jump = 1; branch = 1; zero = 1;
        tick();
        chk("jump_wins", pc_out, 32'h40);
        clr_in();
        tick();
        chk("jump_halted", 32'(halted), 32'h1);

        // Stall for 3 cycles, with an ignored load in RUN.
        load_word(0, ADDI_A);
        load_word(2, ADDI_C);
        load_word(3, ADDI_D);
        load_word(4, HALTW);
        do_start();
        tick();
        stall = 1;
        load_en = 1; load_addr = 6'd2; load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 0;
        tick();
        tick();
        chk("stall_pc",    pc_out,           32'h4);
        chk("stall_instr", instr_out,        32'h1000_FFFF);
        chk("stall_cnt",   32'(instr_count), 32'd2);
        stall = 0;
        tick();
        chk("stall_rel_pc",    pc_out,    32'h8);
        chk("run_load_ignored", instr_out, ADDI_C);
        tick();
        tick();
        chk("halt_word_pc", pc_out, 32'h10);
        stall = 1;
        tick();
        chk("halt_deferred", 32'(valid), 32'h1);
        stall = 0;
        tick();
        chk("halt_after_stall", 32'(halted),      32'h1);
        chk("halt_cnt",         32'(instr_count), 32'd5);

        // Out-of-range fetch: jump to word 64.
        load_word(0, 32'h0800_0040);
        do_start();
        jump = 1;
        tick();
        jump = 0;
        chk("oor_halted", 32'(halted),      32'h1);
        chk("oor_fault",  32'(fault),       32'h1);
        chk("oor_pc",     pc_out,           32'h100);
        chk("oor_instr",  instr_out,        32'h0);
        chk("oor_cnt",    32'(instr_count), 32'd1);
        // Load and start together: the load is seen by the first fetch.
        load_en = 1; load_addr = 6'd0; load_data = ADDI_A; start = 1;
        tick();
        load_en = 0; start = 0;
        chk("restart_fault", 32'(fault), 32'h0);
        chk("restart_pc",    pc_out,     32'h0);
        chk("write_first",   instr_out,  ADDI_A);

        // Reset during RUN at pc 12.
        tick();
        tick();
        tick();
        chk("pre_rst_pc", pc_out, 32'hC);
        rst = 1;
        tick();
        chk_reset("midrun_rst");
        rst = 0;
        do_start();
        chk("post_rst_pc",    pc_out,    32'h0);
        chk("post_rst_instr", instr_out, ADDI_A);
        for (int i = 0; i < 12 && !halted; i++) tick();
        chk("drain_halted", 32'(halted), 32'h1);

        // Counter saturation: jump-to-self loop at word 0.
        load_word(0, 32'h0800_0000);
        do_start();
        jump = 1;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_count", 32'(instr_count), 32'hFFFF);
        chk("sat_pc",    pc_out,           32'h0);
        jump = 0;
        rst = 1;
        tick();
        rst = 0;

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            start     = ($urandom_range(0, 5) == 0);
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = 6'($urandom_range(0, 63));
            load_data = rand_word();
            stall     = ($urandom_range(0, 3) == 0);
            branch    = 1'($urandom);
            branch_ne = 1'($urandom);
            zero      = 1'($urandom);
            jump      = ($urandom_range(0, 7) == 0);
            tick();
        end
        clr_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
